// File: rtl/icache_refill_ctrl_pkg.sv
// icache_refill_ctrl_pkg: FSM encoding, AXI burst constants and line geometry
// shared by the I-cache refill controller and its line buffer.
package icache_refill_ctrl_pkg;
   localparam int LINE_WORDS = 16;
   localparam int OFFSET_W = $clog2(LINE_WORDS) + 2;
   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [2:0] AXI_SIZE_4B = 3'b010;
   typedef enum logic [1:0] {ST_IDLE, ST_AR, ST_R, ST_DONE} state_e;
   function automatic logic [31:0] line_align(input logic [31:0] addr, input int offset_w);
      return addr & ~((32'd1 << offset_w) - 32'd1);
   endfunction
endpackage

// File: rtl/icache_refill_ctrl_if.sv
// icache_refill_ctrl_if: AXI read address and read data channels between the
// refill controller (master) and the core read arbiter (slave).
interface icache_refill_ctrl_if;
   logic        arvalid;
   logic        arready;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic [3:0]  arid;
   logic        rvalid;
   logic        rready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   modport master (
      output arvalid, araddr, arlen, arsize, arburst, arid, rready,
      input  arready, rvalid, rdata, rresp, rlast
   );
   modport slave (
      input  arvalid, araddr, arlen, arsize, arburst, arid, rready,
      output arready, rvalid, rdata, rresp, rlast
   );
endinterface

// File: rtl/icache_line_buf.sv
// icache_line_buf: WORDS x 32 line buffer with one indexed write port and a
// flat read bus; contents are intentionally not reset.
module icache_line_buf #(
   parameter int WORDS = 16
) (
   input  logic                       clk,
   input  logic                       we,
   input  logic [$clog2(WORDS)-1:0]   idx,
   input  logic [31:0]                wdata,
   output logic [32*WORDS-1:0]        rd_line
);
   logic [WORDS-1:0][31:0] mem_q, mem_d;
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end
   always_comb begin
      mem_d = mem_q;
      if (we) mem_d[idx] = wdata;
   end
   assign rd_line = mem_q;
endmodule

// File: rtl/icache_refill_ctrl.sv
// icache_refill_ctrl: issues one AXI INCR read burst per refill request and
// assembles the returned beats into a line for the I-cache main FSM.
module icache_refill_ctrl #(
   parameter int         LINE_WORDS = icache_refill_ctrl_pkg::LINE_WORDS,
   parameter logic [3:0] AXI_ID     = 4'd0
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     r_req,
   input  logic [7:0]               r_length,
   input  logic [31:0]              r_addr,
   input  logic                     uncache,
   input  logic                     r_data_ready,
   output logic                     r_rdy_AXI,
   output logic                     fill_finish,
   output logic [32*LINE_WORDS-1:0] line_data,
   output logic                     bus_err,
   icache_refill_ctrl_if.master     axi
);
   import icache_refill_ctrl_pkg::*;
   localparam int IDX_W = $clog2(LINE_WORDS);
   localparam int OFS_W = IDX_W + 2;
   state_e           state_q, state_d;
   logic [31:0]      araddr_q, araddr_d;
   logic [7:0]       arlen_q, arlen_d;
   logic [IDX_W-1:0] cnt_q, cnt_d;
   logic             bus_err_q, bus_err_d;
   logic             beat;
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q   <= ST_IDLE;
         araddr_q  <= '0;
         arlen_q   <= '0;
         cnt_q     <= '0;
         bus_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         araddr_q  <= araddr_d;
         arlen_q   <= arlen_d;
         cnt_q     <= cnt_d;
         bus_err_q <= bus_err_d;
      end
   end
   // Beat counter wraps naturally at LINE_WORDS, so over-long bursts overwrite from word 0.
   always_comb begin
      state_d   = state_q;
      araddr_d  = araddr_q;
      arlen_d   = arlen_q;
      cnt_d     = cnt_q;
      bus_err_d = bus_err_q;
      case (state_q)
         ST_IDLE: if (r_req) begin
            state_d   = ST_AR;
            araddr_d  = uncache ? r_addr : line_align(r_addr, OFS_W);
            arlen_d   = r_length;
            cnt_d     = '0;
            bus_err_d = 1'b0;
         end
         ST_AR: if (axi.arready) state_d = ST_R;
         ST_R: if (axi.rvalid) begin
            cnt_d     = cnt_q + 1'b1;
            bus_err_d = bus_err_q | (axi.rresp != 2'b00);
            if (axi.rlast) state_d = ST_DONE;
         end
         default: if (r_data_ready) state_d = ST_IDLE;
      endcase
   end
   always_comb begin
      axi.arvalid = state_q == ST_AR;
      axi.rready  = state_q == ST_R;
      r_rdy_AXI   = (state_q == ST_AR) & axi.arready;
      fill_finish = (state_q == ST_DONE) & r_data_ready;
      beat        = (state_q == ST_R) & axi.rvalid;
   end
   assign axi.araddr  = araddr_q;
   assign axi.arlen   = arlen_q;
   assign axi.arsize  = AXI_SIZE_4B;
   assign axi.arburst = AXI_BURST_INCR;
   assign axi.arid    = AXI_ID;
   assign bus_err     = bus_err_q;
   icache_line_buf #(.WORDS(LINE_WORDS)) u_line_buf (
      .clk     (clk),
      .we      (beat),
      .idx     (cnt_q),
      .wdata   (axi.rdata),
      .rd_line (line_data)
   );
endmodule

// File: tb/tb_icache_refill_ctrl.sv
// tb_icache_refill_ctrl: randomized refill bursts with a queue-based scoreboard;
// a negedge monitor checks every AR handshake and every fill_finish.
module tb_icache_refill_ctrl;
   logic         clk = 1'b0;
   logic         rstn = 1'b0;
   logic         r_req = 1'b0;
   logic [7:0]   r_length = '0;
   logic [31:0]  r_addr = '0;
   logic         uncache = 1'b0;
   logic         r_data_ready = 1'b0;
   logic         r_rdy_AXI, fill_finish, bus_err;
   logic [511:0] line_data;
   icache_refill_ctrl_if axi();
   icache_refill_ctrl dut (
      .clk          (clk),
      .rstn         (rstn),
      .r_req        (r_req),
      .r_length     (r_length),
      .r_addr       (r_addr),
      .uncache      (uncache),
      .r_data_ready (r_data_ready),
      .r_rdy_AXI    (r_rdy_AXI),
      .fill_finish  (fill_finish),
      .line_data    (line_data),
      .bus_err      (bus_err),
      .axi          (axi)
   );
   always #5 clk = ~clk;
   typedef struct packed {logic [31:0] a; logic [7:0] l;} ar_t;
   typedef struct packed {logic [511:0] w; logic [15:0] m; logic be;} fill_t;
   ar_t   ar_q[$];
   fill_t fill_q[$];
   ar_t   ea;
   fill_t ef;
   int    n_chk = 0, n_fail = 0;
   logic        chain = 1'b0;
   logic [31:0] nx_addr = '0;
   logic [7:0]  nx_len = '0;
   logic        nx_unc = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic bad(input string nm);
      n_chk++;
      n_fail++;
      $display("FAIL %s", nm);
   endtask

   // Scoreboard monitor: pops the expected response whenever the DUT presents one.
   always @(negedge clk) if (rstn) begin
      chk("r_rdy_AXI_vs_handshake", {31'd0, r_rdy_AXI}, {31'd0, axi.arvalid & axi.arready});
      if (r_rdy_AXI && fill_finish) bad("overlap: r_rdy_AXI=1 and fill_finish=1, expected never both");
      if (r_rdy_AXI) begin
         if (ar_q.size() == 0) bad("unexpected_ar: r_rdy_AXI=1 with no request outstanding");
         else begin
            ea = ar_q.pop_front();
            chk("araddr", axi.araddr, ea.a);
            chk("arlen", {24'd0, axi.arlen}, {24'd0, ea.l});
            chk("arid", {28'd0, axi.arid}, 32'd0);
            chk("arsize", {29'd0, axi.arsize}, 32'd2);
            chk("arburst", {30'd0, axi.arburst}, 32'd1);
            chk("bus_err_cleared", {31'd0, bus_err}, 32'd0);
         end
      end
      if (fill_finish) begin
         if (fill_q.size() == 0) bad("unexpected_fill: fill_finish=1 with no burst outstanding");
         else begin
            ef = fill_q.pop_front();
            for (int i = 0; i < 16; i++)
               if (ef.m[i]) chk($sformatf("word%0d", i), line_data[32*i +: 32], ef.w[32*i +: 32]);
            chk("bus_err_at_fill", {31'd0, bus_err}, {31'd0, ef.be});
         end
      end
   end

   // One refill from request to fill_finish; base!=0 gives data base+k, else random.
   task automatic refill(input logic [31:0] addr, input logic [7:0] len, input logic unc,
                         input logic [31:0] base, input int ar_dly, input int max_gap,
                         input int rdy_dly, input int err_beat, input int abort_at,
                         output int ar_wait);
      fill_t       f;
      logic [31:0] dat [16];
      int          n;
      bit          seen;
      f = '0;
      for (int k = 0; k <= int'(len); k++) begin
         dat[k] = (base != 0) ? base + k : $urandom;
         f.w[32*(k%16) +: 32] = dat[k];
         f.m[k%16] = 1'b1;
      end
      f.be = (err_beat >= 0) && (err_beat <= int'(len));
      ar_q.push_back({unc ? addr : (addr & 32'hFFFF_FFC0), len});
      fill_q.push_back(f);
      r_req = 1'b1; r_addr = addr; r_length = len; uncache = unc;
      n = 0; ar_wait = 0; seen = 0;
      while (n < 100) begin
         axi.arready = n >= ar_dly;
         @(negedge clk);
         if (axi.arvalid) seen = 1;
         else if (!seen) ar_wait++;
         if (axi.arvalid && axi.arready) break;
         @(posedge clk); #1;
         n++;
      end
      if (n >= 100) begin
         bad("ar_timeout: no AR handshake within 100 cycles");
         r_req = 1'b0; axi.arready = 1'b0;
         void'(ar_q.pop_back()); void'(fill_q.pop_back());
         return;
      end
      @(posedge clk); #1;
      r_req = 1'b0; axi.arready = 1'b0;
      for (int k = 0; k <= int'(len); k++) begin
         if (k == abort_at) begin
            rstn = 1'b0;
            @(posedge clk); #1;
            @(negedge clk);
            chk("rst_rready", {31'd0, axi.rready}, 32'd0);
            chk("rst_arvalid", {31'd0, axi.arvalid}, 32'd0);
            chk("rst_fill_finish", {31'd0, fill_finish}, 32'd0);
            chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
            chk("rst_araddr", axi.araddr, 32'd0);
            @(posedge clk); #1;
            rstn = 1'b1;
            void'(fill_q.pop_back());
            return;
         end
         repeat ($urandom_range(max_gap, 0)) begin @(posedge clk); #1; end
         axi.rvalid = 1'b1; axi.rdata = dat[k];
         axi.rresp = (k == err_beat) ? 2'b10 : 2'b00;
         axi.rlast = k == int'(len);
         n = 0;
         @(negedge clk);
         while (!axi.rready && n < 20) begin @(negedge clk); n++; end
         if (!axi.rready) begin
            bad("r_timeout: rready stayed low for 20 cycles");
            axi.rvalid = 1'b0; axi.rlast = 1'b0;
            return;
         end
         if (k == int'(len)) chk("fill_finish_in_rlast_cycle", {31'd0, fill_finish}, 32'd0);
         @(posedge clk); #1;
         axi.rvalid = 1'b0; axi.rlast = 1'b0; axi.rresp = 2'b00;
      end
      repeat (rdy_dly) begin
         r_data_ready = 1'b0;
         @(negedge clk);
         chk("fill_finish_held", {31'd0, fill_finish}, 32'd0);
         chk("bus_err_in_done", {31'd0, bus_err}, {31'd0, f.be});
         @(posedge clk); #1;
      end
      r_data_ready = 1'b1;
      if (chain) begin r_req = 1'b1; r_addr = nx_addr; r_length = nx_len; uncache = nx_unc; end
      @(negedge clk);
      chk("fill_finish_pulse", {31'd0, fill_finish}, 32'd1);
      @(posedge clk); #1;
      r_data_ready = 1'b0;
   endtask

   initial begin
      int          w;
      logic        unc;
      logic [7:0]  len;
      axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = '0; axi.rresp = '0; axi.rlast = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_arvalid", {31'd0, axi.arvalid}, 32'd0);
      chk("reset_rready", {31'd0, axi.rready}, 32'd0);
      chk("reset_fill_finish", {31'd0, fill_finish}, 32'd0);
      chk("reset_r_rdy_AXI", {31'd0, r_rdy_AXI}, 32'd0);
      chk("reset_bus_err", {31'd0, bus_err}, 32'd0);
      chk("reset_araddr", axi.araddr, 32'd0);
      chk("reset_arlen", {24'd0, axi.arlen}, 32'd0);
      @(posedge clk); #1;
      rstn = 1'b1;
      @(posedge clk); #1;
      refill(32'h1C00_0124, 8'd15, 1'b0, 32'hA0, 3, 0, 0, -1, -1, w);
      chk("t1_ar_wait", w, 32'd1);
      refill(32'hBFAF_8004, 8'd0, 1'b1, 32'hDEAD_BEEF, 0, 0, 0, -1, -1, w);
      refill($urandom, 8'd15, 1'b0, 32'd0, 1, 3, 3, -1, -1, w);
      refill($urandom, 8'd15, 1'b0, 32'd0, 0, 1, 2, 5, -1, w);
      refill($urandom, 8'd15, 1'b0, 32'd0, 2, 0, 0, -1, -1, w);
      chain = 1'b1; nx_addr = $urandom; nx_len = 8'd15; nx_unc = 1'b0;
      refill($urandom, 8'd15, 1'b0, 32'd0, 0, 1, 1, -1, -1, w);
      chain = 1'b0;
      refill(nx_addr, nx_len, nx_unc, 32'd0, 0, 0, 0, -1, -1, w);
      chk("b2b_arvalid_rise", w, 32'd1);
      refill($urandom, 8'd15, 1'b0, 32'd0, 0, 1, 0, -1, 7, w);
      repeat (3) begin @(posedge clk); #1; end
      refill($urandom, 8'd15, 1'b0, 32'd0, 1, 2, 1, -1, -1, w);
      for (int t = 0; t < 10; t++) begin
         unc = 1'($urandom_range(1, 0));
         len = unc ? 8'($urandom_range(1, 0)) : 8'd15;
         refill($urandom, len, unc, 32'd0, $urandom_range(3, 0), $urandom_range(3, 0),
                $urandom_range(3, 0), $urandom_range(24, 0), -1, w);
      end
      repeat (5) @(posedge clk);
      chk("ar_q_drained", ar_q.size(), 32'd0);
      chk("fill_q_drained", fill_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
